// File: rtl/bram_fetch_pkg.sv
// bram_fetch_pkg: shared constants and FSM encoding
// for the BRAM streaming read-back engine.
package bram_fetch_pkg;

  localparam int FIFO_DEPTH  = 4;
  localparam int WORD_STRIDE = 4;
  localparam int COUNT_WIDTH = 24;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    DRAIN = ST_DRAIN
  } state_e;

endpackage

// File: rtl/bram_fetch_fifo.sv
// bram_fetch_fifo: registered show-ahead FIFO that
// absorbs BRAM read latency under stream backpressure.
module bram_fetch_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  input  logic                         pop_i,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is cleared too so data_o reads zero out of reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bram_fetch.sv
// bram_fetch: walks a word range of BRAM port B and
// streams each word out on a valid/ready interface.
module bram_fetch
  import bram_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst_active_low,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  BRAM_read_address,
  output logic                   BRAM_read_en,
  input  logic [DATA_WIDTH-1:0]  BRAM_read_data,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   data_valid,
  input  logic                   data_ready
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] CREDITS = FIFO_DEPTH[CW:0];
  localparam logic [ADDR_WIDTH-1:0] STRIDE =
    ADDR_WIDTH'(WORD_STRIDE);

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [COUNT_WIDTH-1:0]   rem_q, rem_d;
  logic [CW-1:0]            inflight_q, inflight_d;
  logic [READ_LATENCY-1:0]  pipe_q, pipe_d;
  logic                     done_q, done_d;

  logic [CW-1:0] fifo_cnt;
  logic          fifo_empty, fifo_full;
  logic          issue, arrive, pop;
  logic          credit_ok, drained;

  // Reads in flight plus words held must fit in the FIFO
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_cnt})
                     < CREDITS;
  assign issue  = (state_q == READ) && credit_ok && !fifo_full;
  assign arrive = pipe_q[READ_LATENCY-1];
  assign pop    = data_valid && data_ready;

  assign drained = (inflight_q == '0) &&
                   (fifo_empty || (fifo_cnt == CW'(1) && pop));

  assign busy              = (state_q != IDLE);
  assign done              = done_q;
  assign BRAM_read_en      = issue;
  assign BRAM_read_address = addr_q;
  assign data_valid        = !fifo_empty;

  always_comb begin
    pipe_d[0] = issue;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case ({issue, arrive})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            addr_d  = base_addr & ~(STRIDE - ADDR_WIDTH'(1));
            rem_d   = word_count;
            state_d = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_d = addr_q + STRIDE;
          rem_d  = rem_q - COUNT_WIDTH'(1);
          if (rem_q == COUNT_WIDTH'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drained) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_active_low) begin
    if (!rst_active_low) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= '0;
      pipe_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      pipe_q     <= pipe_d;
      done_q     <= done_d;
    end
  end

  bram_fetch_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_active_low),
    .push_i  (arrive),
    .data_i  (BRAM_read_data),
    .pop_i   (pop),
    .data_o  (data_out),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule

// File: tb/tb_bram_fetch.sv
// tb_bram_fetch: directed bench driving a latency-1 and a
// latency-2 instance side by side against a word scoreboard.
module tb_bram_fetch;

  localparam logic [31:0] MAGIC = 32'hA5A5_A5A5;
  localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] base;
  logic [23:0] cnt;
  logic        ready;

  logic        busy1, done1, en1, valid1;
  logic [31:0] addr1, rdata1, dout1;
  logic        busy2, done2, en2, valid2;
  logic [31:0] addr2, rdata2, dout2, p2;

  int errors = 0;
  int checks = 0;

  logic [31:0] q1[$];
  logic [31:0] q2[$];
  int iss1 = 0, xf1 = 0, iss2 = 0, xf2 = 0;
  logic stall1 = 0, stall2 = 0;
  logic [31:0] hold1, hold2;

  bram_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32),
               .READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst_active_low(rst_n), .start(start),
    .base_addr(base), .word_count(cnt), .busy(busy1),
    .done(done1), .BRAM_read_address(addr1),
    .BRAM_read_en(en1), .BRAM_read_data(rdata1),
    .data_out(dout1), .data_valid(valid1),
    .data_ready(ready));

  bram_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32),
               .READ_LATENCY(2)) u_l2 (
    .clk(clk), .rst_active_low(rst_n), .start(start),
    .base_addr(base), .word_count(cnt), .busy(busy2),
    .done(done2), .BRAM_read_address(addr2),
    .BRAM_read_en(en2), .BRAM_read_data(rdata2),
    .data_out(dout2), .data_valid(valid2),
    .data_ready(ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM models: junk on non-read cycles exposes misaligned capture
  always @(posedge clk) rdata1 <= en1 ? (addr1 ^ MAGIC) : JUNK;
  always @(posedge clk) begin
    p2     <= en2 ? (addr2 ^ MAGIC) : JUNK;
    rdata2 <= p2;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      xf1 = iss1; stall1 = 1'b0;
    end else begin
      if (stall1) begin
        chk("hold_valid1", 32'(valid1), 32'd1);
        chk("hold_data1", dout1, hold1);
      end
      if (en1) begin
        chk("credit1", 32'(iss1 - xf1 < 4), 32'd1);
        iss1++;
      end
      if (valid1 && ready) begin
        chk("expected1", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) chk("data1", dout1, q1.pop_front());
        xf1++;
      end
      stall1 = valid1 && !ready;
      hold1  = dout1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      xf2 = iss2; stall2 = 1'b0;
    end else begin
      if (stall2) begin
        chk("hold_valid2", 32'(valid2), 32'd1);
        chk("hold_data2", dout2, hold2);
      end
      if (en2) begin
        chk("credit2", 32'(iss2 - xf2 < 4), 32'd1);
        iss2++;
      end
      if (valid2 && ready) begin
        chk("expected2", 32'(q2.size() != 0), 32'd1);
        if (q2.size() != 0) chk("data2", dout2, q2.pop_front());
        xf2++;
      end
      stall2 = valid2 && !ready;
      hold2  = dout2;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] b, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = (b & 32'hFFFF_FFFC) + 32'(4 * i);
      q1.push_back(a ^ MAGIC);
      q2.push_back(a ^ MAGIC);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy1"}, 32'(busy1), 32'd0);
    chk({tag, "_done1"}, 32'(done1), 32'd0);
    chk({tag, "_en1"}, 32'(en1), 32'd0);
    chk({tag, "_valid1"}, 32'(valid1), 32'd0);
    chk({tag, "_addr1"}, addr1, 32'd0);
    chk({tag, "_dout1"}, dout1, 32'd0);
    chk({tag, "_busy2"}, 32'(busy2), 32'd0);
    chk({tag, "_done2"}, 32'(done2), 32'd0);
    chk({tag, "_en2"}, 32'(en2), 32'd0);
    chk({tag, "_valid2"}, 32'(valid2), 32'd0);
    chk({tag, "_addr2"}, addr2, 32'd0);
    chk({tag, "_dout2"}, dout2, 32'd0);
  endtask

  // Ends at the negedge of the cycle where the later done is seen
  task automatic wait_done(input string tag, input bit rnd);
    bit s1 = 0, s2 = 0;
    for (int i = 0; i < 400 && !(s1 && s2); i++) begin
      @(negedge clk);
      if (done1) s1 = 1;
      if (done2) s2 = 1;
      if (!(s1 && s2)) begin
        tick();
        if (rnd) ready = 1'($urandom_range(0, 1));
      end
    end
    chk({tag, "_done"}, 32'(s1 && s2), 32'd1);
    chk({tag, "_q1_empty"}, 32'(q1.size()), 32'd0);
    chk({tag, "_q2_empty"}, 32'(q2.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s1, s2;
    logic [31:0] wrap_a [4];
    rst_n = 1'b0; start = 1'b0; base = '0; cnt = '0; ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check_idle("reset");
    tick(); rst_n = 1'b1; tick();

    // Basic run, cycle-exact
    base = 32'h100; cnt = 24'd4;
    push_exp(32'h100, 4);
    start = 1'b1;
    tick();
    start = 1'b0; base = 32'h0; cnt = 24'd0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk("b_en1", 32'(en1), 32'(c <= 4));
      chk("b_en2", 32'(en2), 32'(c <= 4));
      if (c <= 4) begin
        chk("b_addr1", addr1, 32'h100 + 32'(4 * (c - 1)));
        chk("b_addr2", addr2, 32'h100 + 32'(4 * (c - 1)));
      end
      chk("b_xfer1", 32'(valid1 && ready), 32'(c >= 3 && c <= 6));
      chk("b_xfer2", 32'(valid2 && ready), 32'(c >= 4 && c <= 7));
      chk("b_done1", 32'(done1), 32'(c == 7));
      chk("b_done2", 32'(done2), 32'(c == 8));
      chk("b_busy1", 32'(busy1), 32'(c <= 6));
      chk("b_busy2", 32'(busy2), 32'(c <= 7));
      tick();
    end
    chk("b_q1_empty", 32'(q1.size()), 32'd0);
    chk("b_q2_empty", 32'(q2.size()), 32'd0);

    // Backpressure with random ready
    s1 = iss1; s2 = iss2;
    base = 32'h1000; cnt = 24'd16;
    push_exp(32'h1000, 16);
    start = 1'b1; ready = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    ready = 1'($urandom_range(0, 1));
    wait_done("bp", 1'b1);
    chk("bp_reads1", 32'(iss1 - s1), 32'd16);
    chk("bp_reads2", 32'(iss2 - s2), 32'd16);
    tick(); ready = 1'b1; tick();

    // Zero count
    base = 32'h500; cnt = 24'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("z_done1", 32'(done1), 32'(c == 1));
      chk("z_done2", 32'(done2), 32'(c == 1));
      chk("z_busy1", 32'(busy1), 32'd0);
      chk("z_busy2", 32'(busy2), 32'd0);
      chk("z_en1", 32'(en1), 32'd0);
      chk("z_en2", 32'(en2), 32'd0);
      tick();
    end

    // Address wrap
    wrap_a[0] = 32'hFFFF_FFF8; wrap_a[1] = 32'hFFFF_FFFC;
    wrap_a[2] = 32'h0000_0000; wrap_a[3] = 32'h0000_0004;
    base = 32'hFFFF_FFF8; cnt = 24'd4;
    push_exp(32'hFFFF_FFF8, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("w_addr1", addr1, wrap_a[c-1]);
      chk("w_addr2", addr2, wrap_a[c-1]);
      tick();
    end
    wait_done("wrap", 1'b0);
    tick();

    // Start while busy is ignored
    s1 = iss1; s2 = iss2;
    base = 32'h203; cnt = 24'd6;
    push_exp(32'h200, 6);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; base = 32'h900; cnt = 24'd2;
    tick();
    start = 1'b0;
    wait_done("sb", 1'b0);
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("sb_idle_en1", 32'(en1), 32'd0);
      chk("sb_idle_en2", 32'(en2), 32'd0);
      tick();
    end
    chk("sb_reads1", 32'(iss1 - s1), 32'd6);
    chk("sb_reads2", 32'(iss2 - s2), 32'd6);

    // Reset mid-run after two words
    s1 = xf1;
    base = 32'h300; cnt = 24'd8;
    push_exp(32'h300, 8);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && (xf1 - s1) < 2; i++) begin
      @(negedge clk);
      if ((xf1 - s1) < 2) tick();
    end
    chk("r_two_words", 32'(xf1 - s1), 32'd2);
    tick();
    rst_n = 1'b0;
    q1.delete(); q2.delete();
    @(negedge clk);
    check_idle("mid_rst");
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("r_stale_v1", 32'(valid1), 32'd0);
      chk("r_stale_v2", 32'(valid2), 32'd0);
      tick();
    end
    base = 32'h400; cnt = 24'd3;
    push_exp(32'h400, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("r_addr1", addr1, 32'h400);
    chk("r_addr2", addr2, 32'h400);
    tick();
    wait_done("rerun", 1'b0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
